io_flag_interface: RTL and testbench

//  Device-side responder for the CPU's programmed-I/O instructions (INP/OUT/SFI/SFO).
//  - Input side: accepts characters from an input device over valid/ready into a small

---
 rtl/io_flag_interface.sv | 113 +++++++++++
 tb/tb_io_flag_interface.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_flag_interface.sv
// Device-side responder for INP/OUT programmed I/O: input FIFO feeding INPR/FGI,
// OUTR/FGO feeding an output device, plus sticky underrun/overrun error flags.
module io_flag_interface #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [49:1]       control_word,
  input  logic [DATA_W-1:0] ac_in,
  output logic [DATA_W-1:0] inpr_out,
  output logic              fgi,
  output logic              fgo,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              in_underrun,
  output logic              out_overrun
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic f43;
  logic f44;
  logic push;
  logic load;
  logic unused_cw;

  assign f43       = control_word[43];
  assign f44       = control_word[44];
  assign unused_cw = ^{control_word[49:45], control_word[42:1]};

  assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign out_valid = ~fgo;
  assign push      = in_valid && in_ready;
  // INPR refills only from a registered-empty INPR, so an F43 read always leaves fgi low for a cycle.
  assign load      = !fgi && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inpr_out <= '0;
      fgi      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        inpr_out <= fifo_mem[rd_ptr];
        fgi      <= 1'b1;
      end else if (f43 && fgi) begin
        fgi <= 1'b0;
      end
      unique case ({push, load})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      fgo      <= 1'b1;
    end else begin
      if (f44 && fgo) begin
        out_data <= ac_in;
        fgo      <= 1'b0;
      end else if (!fgo && out_ready) begin
        fgo <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_underrun <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      if (f43 && !fgi) begin
        in_underrun <= 1'b1;
      end else if (clr_err) begin
        in_underrun <= 1'b0;
      end
      if (f44 && !fgo) begin
        out_overrun <= 1'b1;
      end else if (clr_err) begin
        out_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_flag_interface.sv
// Randomized and directed checks of io_flag_interface against a queue-based
// reference model of the INPR/FIFO and OUTR flag rules.
module tb_io_flag_interface;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [49:1]   control_word;
  logic [DW-1:0] ac_in;
  logic [DW-1:0] inpr_out;
  logic          fgi;
  logic          fgo;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          clr_err;
  logic          in_underrun;
  logic          out_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_inpr;
  logic [DW-1:0] m_outr;
  logic          m_fgi;
  logic          m_fgo;
  logic          m_und;
  logic          m_ovr;

  always #5 clk = ~clk;

  io_flag_interface #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .control_word(control_word), .ac_in(ac_in),
    .inpr_out(inpr_out), .fgi(fgi), .fgo(fgo), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_err(clr_err), .in_underrun(in_underrun), .out_overrun(out_overrun)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inpr = '0;
    m_outr = '0;
    m_fgi  = 1'b0;
    m_fgo  = 1'b1;
    m_und  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // One clock edge of the programmed-I/O rules, applied to the inputs being driven.
  task automatic model_step();
    int  sz;
    logic f43, f44, nf;
    if (!reset_n) begin
      model_reset();
      return;
    end
    f43 = control_word[43];
    f44 = control_word[44];
    sz  = mq.size();
    if (f43 && !m_fgi) m_und = 1'b1;
    else if (clr_err)  m_und = 1'b0;
    nf = m_fgi;
    if (!m_fgi && sz != 0) begin
      m_inpr = mq.pop_front();
      nf     = 1'b1;
    end else if (f43 && m_fgi) begin
      nf = 1'b0;
    end
    m_fgi = nf;
    if (in_valid && sz < DEPTH) mq.push_back(in_data);
    if (f44 && !m_fgo) m_ovr = 1'b1;
    else if (clr_err)  m_ovr = 1'b0;
    if (f44 && m_fgo) begin
      m_outr = ac_in;
      m_fgo  = 1'b0;
    end else if (!m_fgo && out_ready) begin
      m_fgo = 1'b1;
    end
  endtask

  task automatic check_all();
    check("inpr_out",    32'(inpr_out),    32'(m_inpr));
    check("fgi",         32'(fgi),         32'(m_fgi));
    check("fgo",         32'(fgo),         32'(m_fgo));
    check("out_valid",   32'(out_valid),   32'(!m_fgo));
    check("out_data",    32'(out_data),    32'(m_outr));
    check("in_ready",    32'(in_ready),    32'(mq.size() < DEPTH));
    check("in_underrun", 32'(in_underrun), 32'(m_und));
    check("out_overrun", 32'(out_overrun), 32'(m_ovr));
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f43, input logic f44,
                       input logic [DW-1:0] ac, input logic ordy, input logic clr);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    control_word     = r[48:0];
    control_word[43] = f43;
    control_word[44] = f44;
    in_valid  = v;
    in_data   = d;
    ac_in     = ac;
    out_ready = ordy;
    clr_err   = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, ordy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fgi"},       32'(fgi),         32'd0);
    check({tag, "_fgo"},       32'(fgo),         32'd1);
    check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    check({tag, "_in_ready"},  32'(in_ready),    32'd1);
    check({tag, "_inpr"},      32'(inpr_out),    32'd0);
    check({tag, "_out_data"},  32'(out_data),    32'd0);
    check({tag, "_und"},       32'(in_underrun), 32'd0);
    check({tag, "_ovr"},       32'(out_overrun), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; control_word = '0; ac_in = '0; in_data = '0;
    in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Single character: visible two edges after the push, consumed by F43.
    cycle(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1'b0);
    check("t2_fgi", 32'(fgi), 32'd1);
    check("t2_inpr", 32'(inpr_out), 32'h41);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t2_fgi_clr", 32'(fgi), 32'd0);

    // Fill INPR plus a full FIFO, then drain through pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_inpr", 32'(inpr_out), 32'h30);
    check("t3_full", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'h35, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_stall", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("t3_gap", 32'(fgi), 32'd0);
      idle(1'b0);
      check("t3_fgi", 32'(fgi), 32'd1);
      check("t3_char", 32'(inpr_out), 32'(8'h31 + k));
    end

    // Output held until the device accepts.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      check("t4_hold", 32'(out_data), 32'h5A);
      check("t4_valid", 32'(out_valid), 32'd1);
    end
    idle(1'b1);
    check("t4_fgo", 32'(fgo), 32'd1);

    // Sticky errors and clear.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    check("t5_ovr", 32'(out_overrun), 32'd1);
    check("t5_outr", 32'(out_data), 32'h11);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_und", 32'(in_underrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_clr_und", 32'(in_underrun), 32'd0);
    check("t5_clr_ovr", 32'(out_overrun), 32'd0);
    idle(1'b1);

    // Asynchronous reset with queued input and a pending output.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check("t6_pre_fgo", 32'(fgo), 32'd0);
    check("t6_pre_cnt", 32'(mq.size()), 32'd3);
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("arst");
    model_reset();
    idle(1'b1);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("t6_no_valid", 32'(out_valid), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 1) == 1), 8'($urandom()), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 8'($urandom()), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
